// File: rtl/fifo_word_packer.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_word_packer
//  Purpose  : Drains a synchronous FIFO. Packs PACK consecutive entries into
//             one wide word, which it presents on a valid/ready port. A flush
//             pulse emits the current partial word.
//  Revision : 1.0  initial release
// ============================================================================
module fifo_word_packer #(
  parameter int DATA_WIDTH = 8,
  parameter int PACK       = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       fifo_empty,
  output logic                       fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]      fifo_rd_data,
  input  logic                       flush,
  output logic                       flush_busy,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_WIDTH*PACK-1:0] out_data,
  output logic [$clog2(PACK):0]      out_count
);

  localparam int CNT_W = $clog2(PACK) + 1;
  localparam int IDX_W = (CNT_W > 1) ? CNT_W - 1 : 1;
  localparam logic [CNT_W-1:0] c_pack = CNT_W'(PACK);

  typedef enum logic [1:0] {
    FILL       = 2'd0,
    FLUSH_WAIT = 2'd1,
    FLUSH_EMIT = 2'd2
  } state_t;

  state_t                             state;
  state_t                             state_next;
  logic [PACK-1:0][DATA_WIDTH-1:0]    acc;
  logic [PACK-1:0][DATA_WIDTH-1:0]    word_masked;
  logic [CNT_W-1:0]                   lane_cnt;
  logic [CNT_W-1:0]                   occupancy;
  logic [IDX_W-1:0]                   lane_idx;
  logic                               pending;
  logic                               can_load;
  logic                               xfer_req;
  logic                               xfer;

  assign lane_idx = lane_cnt[IDX_W-1:0];

  // Only lanes already filled leave the packer; the rest go out as zero.
  for (genvar i = 0; i < PACK; i++) begin : g_lane
    assign word_masked[i] = (CNT_W'(i) < lane_cnt) ? acc[i] : '0;
  end

  // Transfer decision and pop request. The pop counts the entry still in
  // flight, so the accumulator can never overrun.
  always_comb begin
    can_load   = !out_valid || out_ready;
    xfer_req   = (lane_cnt == c_pack) ||
                 ((state == FLUSH_EMIT) && (lane_cnt != '0));
    xfer       = xfer_req && can_load;
    occupancy  = (xfer ? '0 : lane_cnt) + {{(CNT_W-1){1'b0}}, pending};
    fifo_rd_en = !rst && !fifo_empty && (state == FILL) && !flush &&
                 (occupancy < c_pack);
  end

  // Flush sequencing: stop popping, let the in-flight entry land, then emit.
  always_comb begin
    state_next = state;
    flush_busy = (state != FILL);
    case (state)
      FILL:       if (flush) state_next = FLUSH_WAIT;
      FLUSH_WAIT: if (!pending) state_next = FLUSH_EMIT;
      FLUSH_EMIT: if ((lane_cnt == '0) || xfer) state_next = FILL;
      default:    state_next = FILL;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= FILL;
    else     state <= state_next;
  end

  // Read-return capture into the accumulator. On a transfer, a byte arriving
  // in the same cycle starts the next word in lane 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending  <= 1'b0;
      lane_cnt <= '0;
      acc      <= '0;
    end else begin
      pending <= fifo_rd_en;
      if (xfer) begin
        lane_cnt <= pending ? CNT_W'(1) : '0;
        if (pending) acc[0] <= fifo_rd_data;
      end else if (pending) begin
        acc[lane_idx] <= fifo_rd_data;
        lane_cnt      <= lane_cnt + CNT_W'(1);
      end
    end
  end

  // Output word register. A retiring word and a new word can share one edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_count <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= word_masked;
      out_count <= lane_cnt;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_word_packer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_word_packer
//  Purpose  : Directed testbench for fifo_word_packer. A byte-stream model
//             predicts the emitted words.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fifo_word_packer;

  localparam int DW = 8;
  localparam int PK = 4;
  localparam int CW = $clog2(PK) + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             fifo_empty;
  logic             fifo_rd_en;
  logic [DW-1:0]    fifo_rd_data = 8'hEE;
  logic             flush;
  logic             flush_busy;
  logic             out_valid;
  logic             out_ready;
  logic [DW*PK-1:0] out_data;
  logic [CW-1:0]    out_count;

  int checks = 0;
  int errors = 0;

  // Source FIFO: array plus pointers, each pointer written by one process.
  logic [DW-1:0] fmem [256];
  logic [7:0]    wr_ptr = 8'd0;
  logic [7:0]    rd_ptr = 8'd0;
  assign fifo_empty = (wr_ptr == rd_ptr);

  // Model state: bytes popped toward the current word, predicted words,
  // and a log of accepted words.
  logic [DW-1:0]    part [$];
  logic [DW*PK-1:0] exp_data [$];
  int               exp_cnt [$];
  logic [DW*PK-1:0] log_data [$];
  int               log_cnt [$];

  int               pops = 0;
  int               cyc = 0;
  int               last_pop_cyc = 0;
  int               rise_cyc = 0;
  int               busy_cycles = 0;
  logic             rise_busy = 1'b0;
  logic             rst_d = 1'b0;
  logic             ov_d = 1'b0;
  logic             stall_d = 1'b0;
  logic [DW*PK-1:0] hold_data = '0;
  logic [CW-1:0]    hold_count = '0;

  fifo_word_packer #(.DATA_WIDTH(DW), .PACK(PK)) dut (
    .clk          (clk),
    .rst          (rst),
    .fifo_empty   (fifo_empty),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_data (fifo_rd_data),
    .flush        (flush),
    .flush_busy   (flush_busy),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_count    (out_count)
  );

  always #5 clk = ~clk;

  // FIFO read port: data one cycle after the pop, garbage otherwise.
  always @(posedge clk) begin
    if (fifo_rd_en) begin
      fifo_rd_data <= fmem[rd_ptr];
      rd_ptr       <= rd_ptr + 8'd1;
    end else begin
      fifo_rd_data <= 8'hEE;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW*PK-1:0] pack_part();
    logic [DW*PK-1:0] w;
    w = '0;
    for (int i = 0; i < part.size(); i++) w[i*DW +: DW] = part[i];
    return w;
  endfunction

  // Compare process: builds the expected word stream from popped bytes and
  // flushes, and checks the DUT every cycle.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      chk("rd_en_in_reset", {63'd0, fifo_rd_en}, 64'd0);
      if (rst_d) begin
        chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
        chk("reset_out_data", {32'd0, out_data}, 64'd0);
        chk("reset_out_count", {61'd0, out_count}, 64'd0);
        chk("reset_flush_busy", {63'd0, flush_busy}, 64'd0);
      end
      part.delete();
      exp_data.delete();
      exp_cnt.delete();
      stall_d = 1'b0;
    end else begin
      chk("rd_en_while_empty", {63'd0, fifo_rd_en && fifo_empty}, 64'd0);
      if (flush_busy || flush) chk("rd_en_during_flush", {63'd0, fifo_rd_en}, 64'd0);
      if (stall_d) begin
        chk("hold_valid", {63'd0, out_valid}, 64'd1);
        chk("hold_data", {32'd0, out_data}, {32'd0, hold_data});
        chk("hold_count", {61'd0, out_count}, {61'd0, hold_count});
      end
      if (out_valid && !ov_d) begin
        rise_cyc  = cyc;
        rise_busy = flush_busy;
      end
      if (flush_busy) busy_cycles++;
      if (out_valid && out_ready) begin
        log_data.push_back(out_data);
        log_cnt.push_back(int'(out_count));
        if (exp_data.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word actual=%0h required=none", out_data);
        end else begin
          chk("word_data", {32'd0, out_data}, {32'd0, exp_data.pop_front()});
          chk("word_count", {61'd0, out_count}, 64'(exp_cnt.pop_front()));
        end
      end
      if (fifo_rd_en) begin
        pops++;
        last_pop_cyc = cyc;
        part.push_back(fmem[rd_ptr]);
        if (part.size() == PK) begin
          exp_data.push_back(pack_part());
          exp_cnt.push_back(PK);
          part.delete();
        end
      end
      if (flush && !flush_busy && part.size() > 0) begin
        exp_data.push_back(pack_part());
        exp_cnt.push_back(part.size());
        part.delete();
      end
      stall_d    = out_valid && !out_ready;
      hold_data  = out_data;
      hold_count = out_count;
    end
    rst_d = rst;
    ov_d  = out_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] b);
    fmem[wr_ptr] = b;
    wr_ptr = wr_ptr + 8'd1;
  endtask

  task automatic wait_words(input int n, input int maxc, input string nm);
    int k;
    k = 0;
    while (log_data.size() < n && k < maxc) begin
      tick();
      k++;
    end
    if (log_data.size() < n) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=%0d required=%0d words", nm, log_data.size(), n);
    end
  endtask

  task automatic wait_pops(input int target, input int maxc, input string nm);
    int k;
    k = 0;
    while (pops < target && k < maxc) begin
      tick();
      k++;
    end
    if (pops < target) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=%0d required=%0d pops", nm, pops, target);
    end
  endtask

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // Directed stimulus.
  initial begin
    int p0;
    int b0;
    int nlog;
    rst       = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b1;

    // Reset with a non-empty FIFO; these bytes become the first word.
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    repeat (2) tick();
    chk("reset_end_valid", {63'd0, out_valid}, 64'd0);
    chk("reset_end_data", {32'd0, out_data}, 64'd0);
    chk("reset_end_rd_en", {63'd0, fifo_rd_en}, 64'd0);
    p0  = pops;
    rst = 1'b0;

    // Basic pack.
    wait_words(1, 30, "basic");
    chk("basic_pops", 64'(pops - p0), 64'd4);
    chk("basic_data", {32'd0, log_data[0]}, 64'h44332211);
    chk("basic_count", 64'(log_cnt[0]), 64'd4);
    chk("basic_latency", 64'(rise_cyc - last_pop_cyc), 64'd3);
    repeat (5) tick();
    chk("basic_no_extra_pop", 64'(pops - p0), 64'd4);

    // Backpressure.
    out_ready = 1'b0;
    p0 = pops;
    for (int i = 1; i <= 12; i++) push(8'(8'h11 * i));
    repeat (30) tick();
    chk("bp_pops_stop", 64'(pops - p0), 64'd8);
    chk("bp_valid", {63'd0, out_valid}, 64'd1);
    chk("bp_data_held", {32'd0, out_data}, 64'h44332211);
    out_ready = 1'b1;
    wait_words(4, 40, "bp");
    chk("bp_word1", {32'd0, log_data[1]}, 64'h44332211);
    chk("bp_word2", {32'd0, log_data[2]}, 64'h88776655);
    chk("bp_word3", {32'd0, log_data[3]}, 64'hCCBBAA99);
    chk("bp_total_pops", 64'(pops - p0), 64'd12);

    // Partial flush with a fourth entry arriving during the flush.
    repeat (3) tick();
    p0 = pops;
    push(8'hAA); push(8'hBB); push(8'hCC);
    wait_pops(p0 + 3, 10, "pf_pops");
    repeat (4) tick();
    push(8'hDD);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("pf_busy_rise", {63'd0, flush_busy}, 64'd1);
    wait_words(5, 20, "pf");
    chk("pf_data", {32'd0, log_data[4]}, 64'h00CCBBAA);
    chk("pf_count", 64'(log_cnt[4]), 64'd3);
    chk("pf_busy_clear_at_word", {63'd0, rise_busy}, 64'd0);
    repeat (4) tick();
    chk("pf_dd_popped_after", 64'(pops - p0), 64'd4);

    // Flush the single DD entry out as a one-lane word.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wait_words(6, 20, "pf_dd");
    chk("pf_dd_data", {32'd0, log_data[5]}, 64'h000000DD);
    chk("pf_dd_count", 64'(log_cnt[5]), 64'd1);

    // Empty flush.
    repeat (4) tick();
    nlog  = log_data.size();
    b0    = busy_cycles;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    repeat (8) tick();
    chk("ef_no_word", 64'(log_data.size()), 64'(nlog));
    chk("ef_busy_le3", {63'd0, (busy_cycles - b0) >= 1 && (busy_cycles - b0) <= 3}, 64'd1);
    chk("ef_busy_low", {63'd0, flush_busy}, 64'd0);

    // FIFO underflow gap.
    p0 = pops;
    push(8'h5A); push(8'h6B);
    repeat (10) tick();
    chk("uf_pops_gap", 64'(pops - p0), 64'd2);
    chk("uf_no_valid", {63'd0, out_valid}, 64'd0);
    push(8'h7C); push(8'h8D);
    wait_words(7, 20, "uf");
    chk("uf_data", {32'd0, log_data[6]}, 64'h8D7C6B5A);

    // Reset mid-word: two captured, one in flight.
    repeat (3) tick();
    p0 = pops;
    push(8'h10); push(8'h20); push(8'h30);
    wait_pops(p0 + 3, 10, "rm_pops");
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    nlog = log_data.size();
    repeat (10) tick();
    chk("rm_no_word", 64'(log_data.size()), 64'(nlog));
    push(8'h01); push(8'h02); push(8'h03); push(8'h04);
    wait_words(nlog + 1, 20, "rm");
    chk("rm_data", {32'd0, log_data[nlog]}, 64'h04030201);
    chk("rm_count", 64'(log_cnt[nlog]), 64'd4);

    repeat (4) tick();
    chk("model_drained", 64'(exp_data.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
